// File: rtl/elevator_car.sv
// Plant model of a 3-floor elevator car and shaft: the motion and door FSMs driven by
// controller commands, with a sticky fault monitor that checks those command lines.
module elevator_car #(
  parameter int NUM_FLOORS    = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dir_up,
  input  logic       dir_down,
  input  logic       door_open,
  output logic [1:0] cur_floor,
  output logic       moving,
  output logic       arrive,
  output logic       door_closed,
  output logic       door_is_open,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int TW = $clog2(TRAVEL_CYCLES);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [1:0]    TOP_FLOOR   = 2'(NUM_FLOORS - 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] DOOR_LAST   = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {STOPPED, MOVE_UP, MOVE_DOWN, FAULT} motion_t;
  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING}      door_t;

  motion_t       motion_q, motion_d;
  door_t         door_q, door_d;
  logic [TW-1:0] travel_cnt_q, travel_cnt_d;
  logic [DW-1:0] door_cnt_q, door_cnt_d;
  logic [1:0]    floor_q, floor_d;
  logic [1:0]    code_q, code_d;
  logic          arrive_d;
  logic          moving_q, fault_q, door_closed_q, door_is_open_q, arrive_q;

  // Motion FSM. Fault checks come before any floor update, so an overtravel or a
  // fault on the arrival edge leaves cur_floor untouched.
  always_comb begin
    // NOTE: every signal gets a default before the case; a path that skips an assignment would infer a latch.
    motion_d     = motion_q;
    travel_cnt_d = travel_cnt_q;
    floor_d      = floor_q;
    code_d       = code_q;
    arrive_d     = 1'b0;
    unique case (motion_q)
      STOPPED: begin
        if (dir_up && dir_down) begin
          motion_d = FAULT;
          code_d   = 2'b01;
        end else if ((dir_up && floor_q == TOP_FLOOR) || (dir_down && floor_q == 2'd0)) begin
          motion_d = FAULT;
          code_d   = 2'b10;
        end else if (door_q == CLOSED && (dir_up || dir_down)) begin
          // A direction request with the door not fully closed just waits here.
          motion_d     = dir_up ? MOVE_UP : MOVE_DOWN;
          travel_cnt_d = '0;
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (dir_up && dir_down) begin
          motion_d = FAULT;
          code_d   = 2'b01;
        end else if (door_open) begin
          motion_d = FAULT;
          code_d   = 2'b11;
        end else if (travel_cnt_q == TRAVEL_LAST) begin
          motion_d     = STOPPED;
          travel_cnt_d = '0;
          arrive_d     = 1'b1;
          floor_d      = (motion_q == MOVE_UP) ? floor_q + 2'd1 : floor_q - 2'd1;
        end else begin
          travel_cnt_d = travel_cnt_q + TW'(1);
        end
      end
      default: ;  // FAULT is sticky until reset
    endcase
  end

  // Door FSM keeps running in FAULT so a stranded car can still be opened.
  always_comb begin
    door_d     = door_q;
    door_cnt_d = door_cnt_q;
    unique case (door_q)
      CLOSED: begin
        if (door_open && (motion_q == STOPPED || motion_q == FAULT)) begin
          door_d     = OPENING;
          door_cnt_d = '0;
        end
      end
      OPENING: begin
        if (!door_open) begin
          door_d     = CLOSING;
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          door_d     = OPEN;
          door_cnt_d = '0;
        end else begin
          door_cnt_d = door_cnt_q + DW'(1);
        end
      end
      OPEN: begin
        if (!door_open) begin
          door_d     = CLOSING;
          door_cnt_d = '0;
        end
      end
      CLOSING: begin
        if (door_open) begin
          door_d     = OPENING;
          door_cnt_d = '0;
        end else if (door_cnt_q == DOOR_LAST) begin
          door_d     = CLOSED;
          door_cnt_d = '0;
        end else begin
          door_cnt_d = door_cnt_q + DW'(1);
        end
      end
      default: ;
    endcase
  end

  // Status outputs are flopped from next-state so they line up with the state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      motion_q       <= STOPPED;
      door_q         <= CLOSED;
      travel_cnt_q   <= '0;
      door_cnt_q     <= '0;
      floor_q        <= 2'd0;
      code_q         <= 2'b00;
      arrive_q       <= 1'b0;
      moving_q       <= 1'b0;
      fault_q        <= 1'b0;
      door_closed_q  <= 1'b1;
      door_is_open_q <= 1'b0;
    end else begin
      motion_q       <= motion_d;
      door_q         <= door_d;
      travel_cnt_q   <= travel_cnt_d;
      door_cnt_q     <= door_cnt_d;
      floor_q        <= floor_d;
      code_q         <= code_d;
      arrive_q       <= arrive_d;
      moving_q       <= (motion_d == MOVE_UP) || (motion_d == MOVE_DOWN);
      fault_q        <= (motion_d == FAULT);
      door_closed_q  <= (door_d == CLOSED);
      door_is_open_q <= (door_d == OPEN);
    end
  end

  assign cur_floor    = floor_q;
  assign moving       = moving_q;
  assign arrive       = arrive_q;
  assign door_closed  = door_closed_q;
  assign door_is_open = door_is_open_q;
  assign fault        = fault_q;
  assign fault_code   = code_q;

endmodule

// File: tb/tb_elevator_car.sv
// Directed bench for elevator_car (default parameters): travel timing, faults and
// priority, door interlock and reopen, and a behavioural controller loop.
module tb_elevator_car;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dir_up, dir_down, door_open;
  logic [1:0] cur_floor, fault_code;
  logic       moving, arrive, door_closed, door_is_open, fault;

  int vectors = 0;
  int errors  = 0;
  int arrivals;
  logic saw_closed;

  elevator_car #(.NUM_FLOORS(3), .TRAVEL_CYCLES(4), .DOOR_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .dir_up(dir_up), .dir_down(dir_down), .door_open(door_open),
    .cur_floor(cur_floor), .moving(moving), .arrive(arrive),
    .door_closed(door_closed), .door_is_open(door_is_open),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // {cur_floor, moving, arrive, door_closed, door_is_open, fault, fault_code}
  logic [8:0] obs;
  assign obs = {cur_floor, moving, arrive, door_closed, door_is_open, fault, fault_code};

  function automatic logic [8:0] st(input logic [1:0] f, input logic m, input logic a,
                                    input logic dc, input logic dopen, input logic ft,
                                    input logic [1:0] c);
    return {f, m, a, dc, dopen, ft, c};
  endfunction

  task automatic chk(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; dir_up = 1'b0; dir_down = 1'b0; door_open = 1'b0;
    #12;
    chk("reset", obs, st(0, 0, 0, 1, 0, 0, 2'b00));
    rst_n = 1'b1;

    // Two floors up with dir_up held: arrive at edge 5 and edge 10.
    dir_up = 1'b1;
    tick; chk("launch0", obs, st(0, 1, 0, 1, 0, 0, 2'b00));
    repeat (3) tick;
    chk("travel0", obs, st(0, 1, 0, 1, 0, 0, 2'b00));
    tick; chk("arrive1", obs, st(1, 0, 1, 1, 0, 0, 2'b00));
    tick; chk("relaunch1", obs, st(1, 1, 0, 1, 0, 0, 2'b00));
    repeat (4) tick;
    chk("arrive2", obs, st(2, 0, 1, 1, 0, 0, 2'b00));

    // Overtravel at the top, then stickiness and async reset.
    tick; chk("overtravel_up", obs, st(2, 0, 0, 1, 0, 1, 2'b10));
    dir_up = 1'b0; dir_down = 1'b1;
    repeat (3) tick;
    chk("fault_sticky", obs, st(2, 0, 0, 1, 0, 1, 2'b10));
    rst_n = 1'b0;
    #2;
    chk("async_reset", obs, st(0, 0, 0, 1, 0, 0, 2'b00));
    dir_down = 1'b0; rst_n = 1'b1;

    dir_down = 1'b1;
    tick; chk("overtravel_down", obs, st(0, 0, 0, 1, 0, 1, 2'b10));
    dir_down = 1'b0;
    pulse_reset;

    // Dropping the command mid-travel still completes the floor.
    dir_up = 1'b1;
    tick; dir_up = 1'b0;
    repeat (3) tick;
    chk("dir_drop_ignored", obs, st(0, 1, 0, 1, 0, 0, 2'b00));
    tick; chk("arrive_after_drop", obs, st(1, 0, 1, 1, 0, 0, 2'b00));
    dir_up = 1'b1; dir_down = 1'b1;
    tick; chk("both_dirs_stopped", obs, st(1, 0, 0, 1, 0, 1, 2'b01));
    dir_up = 1'b0; dir_down = 1'b0;
    pulse_reset;

    // Door command while moving; later causes do not overwrite the code.
    dir_up = 1'b1;
    tick; dir_up = 1'b0;
    tick; door_open = 1'b1;
    tick; chk("door_while_moving", obs, st(0, 0, 0, 1, 0, 1, 2'b11));
    dir_up = 1'b1; dir_down = 1'b1;
    tick; chk("code_first_only", obs, st(0, 0, 0, 0, 0, 1, 2'b11));
    dir_up = 1'b0; dir_down = 1'b0;
    repeat (4) tick;
    chk("fault_frozen", obs, st(0, 0, 0, 0, 1, 1, 2'b11));
    door_open = 1'b0;
    pulse_reset;

    // Both directions plus door while moving: 01 wins over 11.
    dir_up = 1'b1;
    tick; dir_down = 1'b1; door_open = 1'b1;
    tick; chk("fault_priority", obs, st(0, 0, 0, 1, 0, 1, 2'b01));
    dir_up = 1'b0; dir_down = 1'b0; door_open = 1'b0;
    pulse_reset;

    // Door cycle at floor 1 with a direction request held off during CLOSING.
    dir_up = 1'b1;
    tick; dir_up = 1'b0;
    repeat (4) tick;
    chk("at_floor1", obs, st(1, 0, 1, 1, 0, 0, 2'b00));
    door_open = 1'b1;
    tick; chk("door_opening", obs, st(1, 0, 0, 0, 0, 0, 2'b00));
    repeat (2) tick;
    chk("door_open", obs, st(1, 0, 0, 0, 1, 0, 2'b00));
    repeat (3) tick;
    door_open = 1'b0;
    tick; chk("door_closing", obs, st(1, 0, 0, 0, 0, 0, 2'b00));
    dir_up = 1'b1;
    tick; chk("interlock_hold", obs, st(1, 0, 0, 0, 0, 0, 2'b00));
    tick; chk("door_closed_again", obs, st(1, 0, 0, 1, 0, 0, 2'b00));
    tick; chk("launch_after_close", obs, st(1, 1, 0, 1, 0, 0, 2'b00));
    dir_up = 1'b0;
    repeat (4) tick;
    chk("arrive2_again", obs, st(2, 0, 1, 1, 0, 0, 2'b00));

    // Reopen one clock into CLOSING.
    door_open = 1'b1;
    repeat (3) tick;
    chk("reopen_open", obs, st(2, 0, 0, 0, 1, 0, 2'b00));
    door_open = 1'b0;
    tick; chk("reopen_closing", obs, st(2, 0, 0, 0, 0, 0, 2'b00));
    door_open = 1'b1;
    saw_closed = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (door_closed) saw_closed = 1'b1;
    end
    chk("reopen_open_again", obs, st(2, 0, 0, 0, 1, 0, 2'b00));
    chk("reopen_never_closed", {8'd0, saw_closed}, 9'd0);
    door_open = 1'b0;
    repeat (3) tick;
    chk("reopen_closed", obs, st(2, 0, 0, 1, 0, 0, 2'b00));

    // Behavioural controller: request floor 2 from floor 0, serve the door, go idle.
    pulse_reset;
    arrivals = 0;
    for (int i = 0; i < 40 && !(cur_floor == 2'd2 && !moving); i++) begin
      dir_up = (cur_floor != 2'd2);
      tick;
      if (arrive) arrivals++;
    end
    dir_up = 1'b0;
    chk("loop_floor", {7'd0, cur_floor}, 9'd2);
    chk("loop_arrivals", 9'(arrivals), 9'd2);
    door_open = 1'b1;
    for (int i = 0; i < 20 && !door_is_open; i++) tick;
    chk("loop_door_open", {8'd0, door_is_open}, 9'd1);
    door_open = 1'b0;
    for (int i = 0; i < 20 && !door_closed; i++) tick;
    chk("loop_final", obs, st(2, 0, 0, 1, 0, 0, 2'b00));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
